// File: rtl/extend_arbiter.sv
// extend_arbiter: two-requester round-robin arbiter in front of a shared
// zero/sign extension unit. One operand is accepted at a time; the result
// is held on data_out with the winner's done until that requester drops req.
//
// Optional feature macro: SIGN_EXTEND_EN
//   defined   -> mode0/mode1 select zero (0) or sign (1) extension
//   undefined -> mode inputs are ignored and every result is zero-extended
//
// Handshake: a requester raises reqN and holds it. A one-cycle gntN pulse
// marks the edge on which dataN_in/modeN were captured. doneN rises one
// cycle later with data_out valid, and stays high until reqN is sampled
// low. The other requester's req is ignored until the FSM is back in IDLE.
module extend_arbiter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             mode0,
  input  logic             mode1,
  input  logic [IN_W-1:0]  data0_in,
  input  logic [IN_W-1:0]  data1_in,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [OUT_W-1:0] data_out,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              sel_q;    // requester currently being served
  logic              last_q;   // requester served most recently
  logic [IN_W-1:0]   op_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic [OUT_W-1:0]  data_q;
  logic              win_d;
  logic              fill_d;
  logic [OUT_W-1:0]  ext_d;
  logic              sel_req_d;

`ifdef SIGN_EXTEND_EN
  logic              mode_q;
`else
  logic              unused_mode;
  assign unused_mode = mode0 | mode1;
`endif

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    win_d = 1'b0;
    if (req0 && req1) begin
      win_d = ~last_q;
    end else if (req1) begin
      win_d = 1'b1;
    end
  end

  // Extension of the captured operand; fill bit is 0 unless sign-extending.
  always_comb begin
`ifdef SIGN_EXTEND_EN
    fill_d = mode_q & op_q[IN_W-1];
`else
    fill_d = 1'b0;
`endif
    ext_d     = {{(OUT_W-IN_W){fill_d}}, op_q};
    sel_req_d = sel_q ? req1 : req0;
  end

  // Control FSM with registered grant/done/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;   // requester 1 "served last" so requester 0 is favoured
      op_q    <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      data_q  <= '0;
`ifdef SIGN_EXTEND_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            sel_q   <= win_d;
            op_q    <= win_d ? data1_in : data0_in;
`ifdef SIGN_EXTEND_EN
            mode_q  <= win_d ? mode1 : mode0;
`endif
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= EXT;
          end
        end
        EXT: begin
          data_q  <= ext_d;
          done0_q <= ~sel_q;
          done1_q <= sel_q;
          state_q <= DONE;
        end
        DONE: begin
          if (!sel_req_d) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            last_q  <= sel_q;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign data_out    = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_extend_arbiter.sv
// tb_extend_arbiter: scenario tasks for extend_arbiter. Expected results
// are queued when a request is driven and popped when done rises.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_extend_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, mode0, mode1;
  logic [7:0]  data0_in, data1_in;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] data_out;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          checks;
  int          failures;

  extend_arbiter #(.IN_W(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .mode0      (mode0),
    .mode1      (mode1),
    .data0_in   (data0_in),
    .data1_in   (data1_in),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .data_out   (data_out),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    data0_in = 8'h00; data1_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_gnt(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seen = 1'b1;
    end
  endtask

  task automatic pop_exp(output logic [15:0] e, output bit ok);
    ok = (exp_q.size() != 0);
    e  = ok ? exp_q.pop_front() : 16'hxxxx;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    data0_in = 8'h00; data1_in = 8'h00;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {gnt0, gnt1, done0, done1});
    end
    checks++;
    if (data_out !== 16'h0000) begin
      failures++; $display("FAIL reset_data: got %h expected 0000", data_out);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero_ext();
    bit seen, ok; logic [15:0] e;
    req0 = 1'b1; data0_in = 8'h01; mode0 = 1'b0;
    exp_q.push_back(16'h0001);
    wait_gnt(seen);
    checks++;
    if (!seen || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL zx_gnt: got gnt0=%b gnt1=%b expected gnt0=1 gnt1=0", gnt0, gnt1);
    end
    @(negedge clk);
    checks++;
    if ({gnt0, done0, done1} !== 3'b010) begin
      failures++; $display("FAIL zx_pulse: got gnt0/done0/done1=%b expected 010", {gnt0, done0, done1});
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || data_out !== e) begin
      failures++; $display("FAIL zx_data: got %h expected %h", data_out, e);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL zx_clear: got done0=%b state=%0d expected 0/0", done0, dbg_state);
    end
  endtask

  task automatic test_sign_ext();
    bit seen, ok; logic [15:0] e;
    logic [7:0]  d_tab [3] = '{8'hFF, 8'h80, 8'h7F};
    logic        m_tab [3] = '{1'b1, 1'b0, 1'b1};
`ifdef SIGN_EXTEND_EN
    logic [15:0] x_tab [3] = '{16'hFFFF, 16'h0080, 16'h007F};
`else
    logic [15:0] x_tab [3] = '{16'h00FF, 16'h0080, 16'h007F};
`endif
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1; data1_in = d_tab[i]; mode1 = m_tab[i];
      exp_q.push_back(x_tab[i]);
      wait_gnt(seen);
      checks++;
      if (!seen || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        failures++; $display("FAIL sx_gnt[%0d]: got gnt0=%b gnt1=%b expected 0/1", i, gnt0, gnt1);
      end
      data1_in = ~d_tab[i]; mode1 = ~m_tab[i];
      @(negedge clk);
      pop_exp(e, ok);
      checks++;
      if (!ok || done1 !== 1'b1 || data_out !== e) begin
        failures++; $display("FAIL sx_data[%0d]: got done1=%b data=%h expected 1/%h", i, done1, data_out, e);
      end
      req1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    bit seen, ok; logic [15:0] e;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0_in = 8'h1A; data1_in = 8'h2E;
    exp_q.push_back(16'h001A);
    exp_q.push_back(16'h002E);
    exp_q.push_back(16'h001A);
    wait_gnt(seen);
    checks++;
    if (!seen || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL rr_first: got gnt0=%b gnt1=%b expected 1/0", gnt0, gnt1);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || {done0, done1} !== 2'b10 || data_out !== e) begin
      failures++; $display("FAIL rr_data0: got done=%b data=%h expected 10/%h", {done0, done1}, data_out, e);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0} !== 3'b000) begin
      failures++; $display("FAIL rr_gap: got gnt0/gnt1/done0=%b expected 000", {gnt0, gnt1, done0});
    end
    req0 = 1'b1;
    wait_gnt(seen);
    checks++;
    if (!seen || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      failures++; $display("FAIL rr_second: got gnt0=%b gnt1=%b expected 0/1", gnt0, gnt1);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || {done0, done1} !== 2'b01 || data_out !== e) begin
      failures++; $display("FAIL rr_data1: got done=%b data=%h expected 01/%h", {done0, done1}, data_out, e);
    end
    req1 = 1'b0;
    wait_gnt(seen);
    checks++;
    if (!seen || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL rr_third: got gnt0=%b gnt1=%b expected 1/0", gnt0, gnt1);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || done0 !== 1'b1 || data_out !== e) begin
      failures++; $display("FAIL rr_data2: got done0=%b data=%h expected 1/%h", done0, data_out, e);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_change();
    bit seen, ok; logic [15:0] e;
    req0 = 1'b1; data0_in = 8'h30; mode0 = 1'b0;
    exp_q.push_back(16'h0030);
    wait_gnt(seen);
    data0_in = 8'h34;
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!seen || !ok || done0 !== 1'b1 || data_out !== e) begin
      failures++; $display("FAIL hold_operand: got done0=%b data=%h expected 1/%h", done0, data_out, e);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop_in_ext();
    bit seen, ok; logic [15:0] e;
    req0 = 1'b1; data0_in = 8'hC3; mode0 = 1'b1;
`ifdef SIGN_EXTEND_EN
    exp_q.push_back(16'hFFC3);
`else
    exp_q.push_back(16'h00C3);
`endif
    wait_gnt(seen);
    req0 = 1'b0;
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!seen || !ok || done0 !== 1'b1 || data_out !== e) begin
      failures++; $display("FAIL drop_ext_done: got done0=%b data=%h expected 1/%h", done0, data_out, e);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || dbg_state !== 2'd0 || data_out !== e) begin
      failures++; $display("FAIL drop_ext_idle: got done0=%b state=%0d data=%h expected 0/0/%h", done0, dbg_state, data_out, e);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, ok; logic [15:0] e;
    req0 = 1'b1; data0_in = 8'h77; mode0 = 1'b0;
    exp_q.push_back(16'h0077);
    wait_gnt(seen);
    checks++;
    if (!seen || dbg_state !== 2'd1) begin
      failures++; $display("FAIL rstmid_ext: got state=%0d expected 1", dbg_state);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000 || data_out !== 16'h0000 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL rstmid_clear: got flags=%b data=%h state=%0d expected 0000/0000/0",
                           {gnt0, gnt1, done0, done1}, data_out, dbg_state);
    end
    exp_q.delete();
    exp_q.push_back(16'h0077);
    @(negedge clk);
    rst = 1'b1;
    wait_gnt(seen);
    checks++;
    if (!seen || gnt0 !== 1'b1) begin
      failures++; $display("FAIL rstmid_regnt: got gnt0=%b expected 1", gnt0);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || done0 !== 1'b1 || data_out !== e) begin
      failures++; $display("FAIL rstmid_data: got done0=%b data=%h expected 1/%h", done0, data_out, e);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_done();
    bit seen, ok; logic [15:0] e;
    do_reset();
    req0 = 1'b1; data0_in = 8'h11; req1 = 1'b1; data1_in = 8'h22;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    wait_gnt(seen);
    checks++;
    if (!seen || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL hold_gnt0: got gnt0=%b gnt1=%b expected 1/0", gnt0, gnt1);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || done0 !== 1'b1 || data_out !== e) begin
      failures++; $display("FAIL hold_data0: got done0=%b data=%h expected 1/%h", done0, data_out, e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({done0, done1, gnt0, gnt1} !== 4'b1000) begin
        failures++; $display("FAIL hold_wait[%0d]: got done0/done1/gnt0/gnt1=%b expected 1000", i, {done0, done1, gnt0, gnt1});
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done0, gnt1} !== 2'b00) begin
      failures++; $display("FAIL hold_turn: got done0/gnt1=%b expected 00", {done0, gnt1});
    end
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      failures++; $display("FAIL hold_gnt1: got gnt0=%b gnt1=%b expected 0/1", gnt0, gnt1);
    end
    @(negedge clk);
    pop_exp(e, ok);
    checks++;
    if (!ok || {done0, done1} !== 2'b01 || data_out !== e) begin
      failures++; $display("FAIL hold_data1: got done=%b data=%h expected 01/%h", {done0, done1}, data_out, e);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  // sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_zero_ext();
    test_sign_ext();
    test_round_robin();
    test_data_change();
    test_drop_in_ext();
    test_reset_mid();
    test_hold_done();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
